// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter PUF challenge sequencer.
// State encoding, settle floor and response bit-order convention.
package puf_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_PREP   = 3'd2;
    localparam state_t ST_SETTLE = 3'd3;
    localparam state_t ST_SAMPLE = 3'd4;
    localparam state_t ST_STEP   = 3'd5;
    localparam state_t ST_DONE   = 3'd6;

    // Two synchronizer flops plus one margin cycle must fit inside SETTLE.
    localparam int MIN_SETTLE_CYCLES = 3;

    // First challenge's response lands in the MSB of the response word.
    localparam bit FIRST_RESP_MSB = 1'b1;

endpackage

// File: rtl/puf_sync.sv
// Two-flop synchronizer for the asynchronous arbiter response.
// Latency 2 clocks; resets both flops to 0.
module puf_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Run controller: seeds the challenge LFSR, launches/samples each race, packs the bits.
// Each bit costs SETTLE_CYCLES+3 clocks; the finished word waits in DONE until resp_ready.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int NUM_CHALLENGES = 16,
    parameter int SETTLE_CYCLES  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH-1:0]          seed,
    output logic                      lfsr_load,
    output logic [WIDTH-1:0]          lfsr_seed,
    output logic                      lfsr_inc,
    output logic                      puf_launch,
    input  logic                      puf_response,
    output logic [NUM_CHALLENGES-1:0] resp_data,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      busy
);

    // Settle window is clamped so the synchronizer always sees the settled level.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < MIN_SETTLE_CYCLES) ? MIN_SETTLE_CYCLES
                                                                    : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(SETTLE_EFF + 1);
    localparam int IDX_W = $clog2(NUM_CHALLENGES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHALLENGES - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [CNT_W-1:0]          settle_cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [NUM_CHALLENGES-1:0] resp_q;
    logic [WIDTH-1:0]          seed_q;
    logic                      sync_resp;

    puf_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (puf_response),
        .q     (sync_resp)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_PREP;
            ST_PREP:   state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == CNT_LAST) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = (bit_idx == IDX_LAST) ? ST_DONE : ST_STEP;
            ST_STEP:   state_nxt = ST_PREP;
            ST_DONE:   if (resp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            bit_idx    <= '0;
            resp_q     <= '0;
            seed_q     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        seed_q  <= seed;
                        resp_q  <= '0;
                        bit_idx <= '0;
                    end
                end
                ST_PREP:   settle_cnt <= '0;
                ST_SETTLE: settle_cnt <= settle_cnt + CNT_W'(1);
                ST_SAMPLE: begin
                    // Cast-truncation keeps this legal for a one-bit word.
                    if (FIRST_RESP_MSB)
                        resp_q <= NUM_CHALLENGES'({resp_q, sync_resp});
                    else
                        resp_q <= NUM_CHALLENGES'({sync_resp, resp_q} >> 1);
                    bit_idx <= bit_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign lfsr_load  = (state == ST_LOAD);
    assign lfsr_inc   = (state == ST_STEP);
    assign puf_launch = (state == ST_SETTLE);
    assign resp_valid = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);
    assign lfsr_seed  = seed_q;
    assign resp_data  = resp_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer with N=4, S=4, WIDTH=8.
module tb_puf_challenge_sequencer;

    localparam int W = 8;
    localparam int N = 4;
    localparam int S = 4;
    localparam int RUN_CYC = N * (S + 3);

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] seed = '0;
    logic         lfsr_load, lfsr_inc, puf_launch, resp_valid, busy;
    logic [W-1:0] lfsr_seed;
    logic         puf_response = 1'b0;
    logic [N-1:0] resp_data;
    logic         resp_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int launch_run = 0;

    puf_challenge_sequencer #(.WIDTH(W), .NUM_CHALLENGES(N), .SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .seed         (seed),
        .lfsr_load    (lfsr_load),
        .lfsr_seed    (lfsr_seed),
        .lfsr_inc     (lfsr_inc),
        .puf_launch   (puf_launch),
        .puf_response (puf_response),
        .resp_data    (resp_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Overlap and launch-width checker, active on every cycle of every run.
    always @(negedge clk) begin
        if (reset) begin
            launch_run = 0;
        end else begin
            chk("strobe_overlap", 32'(int'(lfsr_load) + int'(lfsr_inc) + int'(puf_launch) > 1), 32'd0);
            if (puf_launch) begin
                launch_run++;
            end else if (launch_run != 0) begin
                chk("launch_width", 32'(launch_run), 32'(S));
                launch_run = 0;
            end
        end
    end

    typedef struct {
        logic [W-1:0] seed;
        logic [N-1:0] pat;       // pat[N-1] is driven for the first challenge
        logic [N-1:0] exp_data;
        int           bp_cycles;
        bit           poke_start;
    } vec_t;

    vec_t vecs[5];

    task automatic do_run(input vec_t v);
        int inc_cnt;
        int bitno;
        logic [N-1:0] held;
        inc_cnt = 0;
        bitno   = 0;
        @(negedge clk);
        start        = 1'b1;
        seed         = v.seed;
        puf_response = v.pat[N-1];
        @(posedge clk);               // E0
        for (int cyc = 0; cyc <= RUN_CYC; cyc++) begin
            @(negedge clk);
            start = (v.poke_start && cyc == 10) ? 1'b1 : 1'b0;
            seed  = ~v.seed;
            chk("load_timing", 32'(lfsr_load), 32'(cyc == 0));
            chk("valid_timing", 32'(resp_valid), 32'(cyc == RUN_CYC));
            chk("busy_in_run", 32'(busy), 32'd1);
            if (lfsr_inc) begin
                inc_cnt++;
                bitno++;
                if (bitno < N) puf_response = v.pat[N-1-bitno];
            end
        end
        chk("inc_count", 32'(inc_cnt), 32'(N - 1));
        chk("resp_data", 32'(resp_data), 32'(v.exp_data));
        chk("lfsr_seed", 32'(lfsr_seed), 32'(v.seed));
        held = resp_data;
        for (int k = 0; k < v.bp_cycles; k++) begin
            @(negedge clk);
            chk("bp_data_stable", 32'(resp_data), 32'(held));
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_valid", 32'(resp_valid), 32'd1);
        end
        resp_ready = 1'b1;
        start      = v.poke_start;    // start alongside the handshake must be dropped
        @(negedge clk);
        resp_ready = 1'b0;
        start      = 1'b0;
        chk("idle_after_hs", 32'(busy), 32'd0);
        chk("valid_after_hs", 32'(resp_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_spurious_load", 32'({lfsr_load, busy}), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{seed: 8'hA5, pat: 4'b1111, exp_data: 4'hF, bp_cycles: 0,  poke_start: 1'b0};
        vecs[1] = '{seed: 8'h5A, pat: 4'b1010, exp_data: 4'hA, bp_cycles: 10, poke_start: 1'b1};
        vecs[2] = '{seed: 8'h01, pat: 4'b0000, exp_data: 4'h0, bp_cycles: 2,  poke_start: 1'b0};
        vecs[3] = '{seed: 8'hFF, pat: 4'b0011, exp_data: 4'h3, bp_cycles: 1,  poke_start: 1'b1};
        vecs[4] = '{seed: 8'h80, pat: 4'b1000, exp_data: 4'h8, bp_cycles: 0,  poke_start: 1'b0};

        #1;
        chk("rst_outputs", 32'({lfsr_load, lfsr_inc, puf_launch, resp_valid, busy}), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_lfsr_seed", 32'(lfsr_seed), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) do_run(vecs[i]);

        // Reset during the second SETTLE cycle of the first bit.
        @(negedge clk);
        start        = 1'b1;
        seed         = 8'h77;
        puf_response = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc <= 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_reset_launch", 32'(puf_launch), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_outputs", 32'({lfsr_load, lfsr_inc, puf_launch, resp_valid, busy}), 32'd0);
        chk("mid_rst_resp_data", 32'(resp_data), 32'd0);
        chk("mid_rst_lfsr_seed", 32'(lfsr_seed), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_valid", 32'(resp_valid), 32'd0);
        do_run('{seed: 8'h3C, pat: 4'b0110, exp_data: 4'h6, bp_cycles: 0, poke_start: 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
